// File: rtl/spi_cmd_queue_if.sv
// Bus bundle between command producers / response consumers, the queue, and the SPI master.
// The slave modport is the queue's view; master is the view of everything around it.
interface spi_cmd_queue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [5:0]  cmd_nbits;
  logic        cmd_rd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  logic        m_request;
  logic [31:0] m_mosi_data;
  logic [5:0]  m_nbits;
  logic        m_ready;
  logic [31:0] m_miso_data;

  modport slave (
    input  cmd_valid, cmd_data, cmd_nbits, cmd_rd,
    input  rsp_ready,
    input  m_ready, m_miso_data,
    output cmd_ready, rsp_valid, rsp_data,
    output m_request, m_mosi_data, m_nbits
  );

  modport master (
    output cmd_valid, cmd_data, cmd_nbits, cmd_rd,
    output rsp_ready,
    output m_ready, m_miso_data,
    input  cmd_ready, rsp_valid, rsp_data,
    input  m_request, m_mosi_data, m_nbits
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// SPI command queue: command FIFO -> one-at-a-time sequencer -> SPI master,
// with MISO words of read commands collected in a first-word fall-through response FIFO.
module spi_cmd_queue #(
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 8
) (
  input  logic                 clk_in,
  input  logic                 nrst,
  spi_cmd_queue_if.slave       bus,
  output logic                 busy,
  output logic [6:0]           cmd_level,
  output logic [15:0]          done_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam logic [6:0] CMD_FULL = 7'(CMD_DEPTH);
  localparam logic [6:0] RSP_FULL = 7'(RSP_DEPTH);

  typedef struct packed {
    logic        rd;
    logic [5:0]  nbits;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t           cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr;
  logic [CAW-1:0] cmd_rd_ptr;
  logic [6:0]     cmd_count;
  cmd_t           cmd_head;
  logic           cmd_push;
  logic           cmd_pop;

  assign bus.cmd_ready = (cmd_count != CMD_FULL);
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  assign cmd_head      = cmd_mem[cmd_rd_ptr];
  assign cmd_level     = cmd_count;

  // NOTE: FIFO storage has no reset; the pointers and counts alone decide which
  // entries are valid, so the arrays can map onto plain flops or RAM.
  always_ff @(posedge clk_in) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr] <= {bus.cmd_rd, bus.cmd_nbits, bus.cmd_data};
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 7'd1;
        2'b01:   cmd_count <= cmd_count - 7'd1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr;
  logic [RAW-1:0] rsp_rd_ptr;
  logic [6:0]     rsp_count;
  logic           rsp_full;
  logic           rsp_push_req;
  logic           rsp_push;
  logic           rsp_pop;

  assign rsp_full      = (rsp_count == RSP_FULL);
  assign rsp_push      = rsp_push_req && !rsp_full;
  assign bus.rsp_valid = (rsp_count != 7'd0);
  assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;
  // Head is masked to zero while empty so the reset-time output is defined.
  assign bus.rsp_data  = bus.rsp_valid ? rsp_mem[rsp_rd_ptr] : 32'd0;

  always_ff @(posedge clk_in) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr] <= bus.m_miso_data;
    end
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 7'd1;
        2'b01:   rsp_count <= rsp_count - 7'd1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic        done_inc;
  logic        rd_pending;
  logic        m_request_q;
  logic [31:0] m_mosi_q;
  logic [5:0]  m_nbits_q;
  logic [15:0] done_q;

  // NOTE: combinational processes assign every output a default first and use
  // blocking '=', so no path can leave a value held (no latch); clocked state uses '<='.
  always_comb begin
    state_d      = state_q;
    cmd_pop      = 1'b0;
    rsp_push_req = 1'b0;
    done_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        // A read waits at the head until the response FIFO has room; no bypass.
        if ((cmd_count != 7'd0) && (!cmd_head.rd || !rsp_full)) begin
          cmd_pop = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.m_ready) begin
          rsp_push_req = rd_pending;
          done_inc     = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      m_request_q <= 1'b0;
      m_mosi_q    <= '0;
      m_nbits_q   <= '0;
      rd_pending  <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Request is high only for the ISSUE cycle that follows each pop.
      m_request_q <= cmd_pop;
      if (cmd_pop) begin
        m_mosi_q   <= cmd_head.data;
        m_nbits_q  <= cmd_head.nbits;
        rd_pending <= cmd_head.rd;
      end
      if (done_inc) begin
        done_q <= done_q + 16'd1;
      end
    end
  end

  assign bus.m_request   = m_request_q;
  assign bus.m_mosi_data = m_mosi_q;
  assign bus.m_nbits     = m_nbits_q;
  assign done_count      = done_q;
  assign busy            = (state_q != IDLE) || (cmd_count != 7'd0);

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Self-checking bench for spi_cmd_queue: an in-bench SPI master/slave model with a
// command log and a response log as the reference, plus directed and random stimulus.
module tb_spi_cmd_queue;

  localparam int CMD_DEPTH = 8;
  localparam int RSP_DEPTH = 2;
  localparam int BUDGET    = 3000;

  typedef struct packed {
    logic        rd;
    logic [5:0]  nbits;
    logic [31:0] data;
  } tcmd_t;

  logic        clk;
  logic        nrst;
  logic        busy;
  logic [6:0]  cmd_level;
  logic [15:0] done_count;

  spi_cmd_queue_if bus ();

  spi_cmd_queue #(
    .CMD_DEPTH (CMD_DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk_in     (clk),
    .nrst       (nrst),
    .bus        (bus),
    .busy       (busy),
    .cmd_level  (cmd_level),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: commands in push order, expected responses in completion order.
  tcmd_t       cmd_log [256];
  logic [31:0] rsp_log [256];
  int cmd_wr_idx = 0, cmd_rd_idx = 0;
  int rsp_wr = 0, rsp_rd = 0;
  int n_req = 0, n_pops = 0, pop_limit = 0;
  int exp_done = 0;
  int lat_min = 1, lat_max = 1;
  int xfer_cnt = 0;
  bit loop_mode = 1'b0, rsp_rand = 1'b0, req_prev = 1'b0, cur_rd = 1'b0;
  logic [31:0] cur_miso = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave device behind the master: echoes MOSI in loopback mode, otherwise scrambles it.
  function automatic logic [31:0] miso_fn(input logic [31:0] d);
    if (loop_mode) return d;
    return {d[15:0], d[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // One clock cycle: advance to the falling edge, then run the master model and consumer.
  task automatic step();
    bit want;
    tcmd_t c;
    @(negedge clk);
    if (!nrst) begin
      bus.m_ready   = 1'b0;
      bus.rsp_ready = 1'b0;
      xfer_cnt      = 0;
      req_prev      = 1'b0;
      cmd_rd_idx    = cmd_wr_idx;
      rsp_rd        = rsp_wr;
      return;
    end
    if (bus.m_request) begin
      check("req_pulse_width", 32'(req_prev), 32'd0);
      if (cmd_rd_idx == cmd_wr_idx) begin
        check("req_unexpected", 32'd1, 32'd0);
      end else begin
        c = cmd_log[cmd_rd_idx % 256];
        check("m_mosi_data", bus.m_mosi_data, c.data);
        check("m_nbits", 32'(bus.m_nbits), 32'(c.nbits));
        cur_rd   = c.rd;
        cur_miso = miso_fn(c.data);
        cmd_rd_idx++;
      end
      n_req++;
      bus.m_ready = 1'b0;
      xfer_cnt    = $urandom_range(lat_max, lat_min);
    end else if (xfer_cnt > 0) begin
      xfer_cnt--;
      if (xfer_cnt == 0) begin
        bus.m_ready     = 1'b1;
        bus.m_miso_data = cur_miso;
        if (cur_rd) begin
          rsp_log[rsp_wr % 256] = cur_miso;
          rsp_wr++;
        end
      end
    end
    req_prev = bus.m_request;

    want = rsp_rand ? ($urandom_range(1, 0) == 1) : (n_pops < pop_limit);
    bus.rsp_ready = want;
    if (want && bus.rsp_valid) begin
      if (rsp_rd == rsp_wr) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        check("rsp_data", bus.rsp_data, rsp_log[rsp_rd % 256]);
        rsp_rd++;
      end
      n_pops++;
    end
  endtask

  task automatic push_cmd(input bit rd, input logic [5:0] nbits, input logic [31:0] data);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_rd    = rd;
    bus.cmd_nbits = nbits;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && t < BUDGET) begin
      step();
      t++;
    end
    if (t >= BUDGET) check("push_timeout", 32'd0, 32'd1);
    cmd_log[cmd_wr_idx % 256] = '{rd: rd, nbits: nbits, data: data};
    cmd_wr_idx++;
    exp_done++;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < BUDGET) begin
      step();
      t++;
    end
    check("idle_timeout", 32'(t < BUDGET), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"},  32'(bus.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"},   bus.rsp_data, 32'd0);
    check({tag, "_m_request"},  32'(bus.m_request), 32'd0);
    check({tag, "_m_mosi"},     bus.m_mosi_data, 32'd0);
    check({tag, "_m_nbits"},    32'(bus.m_nbits), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_cmd_level"},  32'(cmd_level), 32'd0);
    check({tag, "_done_count"}, 32'(done_count), 32'd0);
  endtask

  initial begin
    int base_req, base_pops, t;
    nrst            = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_data    = '0;
    bus.cmd_nbits   = '0;
    bus.cmd_rd      = 1'b0;
    bus.rsp_ready   = 1'b0;
    bus.m_ready     = 1'b0;
    bus.m_miso_data = '0;
    repeat (3) step();
    check_reset_values("reset");
    nrst = 1'b1;
    step();

    // Single write: one pulse one cycle after the push, no response.
    pop_limit = 1 << 30;
    lat_min = 4; lat_max = 4;
    push_cmd(1'b0, 6'd7, 32'h0000_00A5);
    check("wr_pre_request", 32'(bus.m_request), 32'd0);
    check("wr_level_queued", 32'(cmd_level), 32'd1);
    check("wr_busy_queued", 32'(busy), 32'd1);
    step();
    check("wr_request", 32'(bus.m_request), 32'd1);
    check("wr_mosi", bus.m_mosi_data, 32'h0000_00A5);
    check("wr_nbits", 32'(bus.m_nbits), 32'd7);
    wait_idle();
    check("wr_done_count", 32'(done_count), 32'(exp_done));
    check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("wr_req_count", 32'(n_req), 32'd1);
    check("wr_mosi_hold", bus.m_mosi_data, 32'h0000_00A5);

    // Read loopback: response held until released, then popped.
    loop_mode = 1'b1;
    pop_limit = n_pops;
    push_cmd(1'b1, 6'd15, 32'h0000_1234);
    wait_idle();
    step();
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_rsp_data", bus.rsp_data, 32'h0000_1234);
    pop_limit = n_pops + 1;
    repeat (3) step();
    check("rd_rsp_popped", 32'(bus.rsp_valid), 32'd0);

    // Queue full behind a slow master.
    pop_limit = 1 << 30;
    lat_min = 40; lat_max = 40;
    base_req = n_req;
    for (int i = 0; i < 9; i++) push_cmd(1'b0, 6'd31, 32'hF000_0000 + 32'(i));
    check("full_level", 32'(cmd_level), 32'd8);
    check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    push_cmd(1'b0, 6'd31, 32'hF000_0009);
    check("full_holdoff_req", 32'(n_req - base_req), 32'd2);
    wait_idle();
    check("full_done_count", 32'(done_count), 32'(exp_done));
    check("full_req_count", 32'(n_req - base_req), 32'd10);

    // Response back-pressure with a two-entry response FIFO.
    lat_min = 3; lat_max = 3;
    pop_limit = n_pops;
    base_req = n_req;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 6'd11, 32'h0000_0B00 + 32'(i));
    t = 0;
    while (32'(done_count) != 32'(exp_done - 1) && t < BUDGET) begin
      step();
      t++;
    end
    check("bp_wait_timeout", 32'(t < BUDGET), 32'd1);
    repeat (10) step();
    check("bp_req_count", 32'(n_req - base_req), 32'd2);
    check("bp_m_request", 32'(bus.m_request), 32'd0);
    check("bp_level", 32'(cmd_level), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    pop_limit = n_pops + 1;
    wait_idle();
    check("bp_req_after_pop", 32'(n_req - base_req), 32'd3);
    pop_limit = 1 << 30;
    repeat (6) step();
    check("bp_drained", 32'(bus.rsp_valid), 32'd0);

    // Mixed burst: alternating read/write, reads come back in order.
    base_pops = n_pops;
    for (int i = 1; i <= 5; i++) push_cmd((i % 2) == 1, 6'd7, 32'(i * 'h11));
    wait_idle();
    repeat (6) step();
    check("mix_done_count", 32'(done_count), 32'(exp_done));
    check("mix_rsp_count", 32'(n_pops - base_pops), 32'd3);

    // Async reset while the sequencer waits on the master.
    pop_limit = n_pops;
    lat_min = 2; lat_max = 2;
    push_cmd(1'b1, 6'd3, 32'h0000_0007);
    wait_idle();
    step();
    lat_min = 30; lat_max = 30;
    base_req = n_req;
    push_cmd(1'b0, 6'd9, 32'h0000_0155);
    push_cmd(1'b1, 6'd9, 32'h0000_02AA);
    repeat (5) step();
    check("rst_pre_busy", 32'(busy), 32'd1);
    check("rst_pre_level", 32'(cmd_level), 32'd1);
    check("rst_pre_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #2 nrst = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) step();
    nrst = 1'b1;
    exp_done = 0;
    step();
    pop_limit = 1 << 30;
    lat_min = 2; lat_max = 2;
    push_cmd(1'b1, 6'd15, 32'h0000_CAFE);
    wait_idle();
    repeat (6) step();
    check("post_rst_done", 32'(done_count), 32'd1);
    check("post_rst_rsp_empty", 32'(bus.rsp_valid), 32'd0);

    // Random traffic with random master latency and random consumer.
    loop_mode = 1'b0;
    rsp_rand = 1'b1;
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(3, 0)) step();
      push_cmd(1'($urandom_range(1, 0)), 6'($urandom_range(31, 0)), $urandom());
    end
    rsp_rand = 1'b0;
    wait_idle();
    repeat (20) step();
    check("rand_done_count", 32'(done_count), 32'(exp_done));
    check("rand_rsp_empty", 32'(bus.rsp_valid), 32'd0);
    check("rand_rsp_all_seen", 32'(rsp_rd), 32'(rsp_wr));
    check("rand_cmd_all_issued", 32'(cmd_rd_idx), 32'(cmd_wr_idx));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
